// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencing controller for the 5-stage RV32I pipeline.
// Drives PC/IF/ID/ID-EX controls from redirect, load-use, imem wait and boot conditions.
module fetch_ctrl #(
  parameter int unsigned BOOT_CYCLES = 4,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             PCSel,
  input  logic             ex_mem_read,
  input  logic [4:0]       ex_rd,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             imem_ready,
  output logic             imem_req,
  output logic             pc_we,
  output logic             pc_src,
  output logic             ifid_we,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int unsigned BW = (BOOT_CYCLES > 1) ? $clog2(BOOT_CYCLES) : 1;
  localparam logic [BW-1:0] BOOT_LAST = BW'(BOOT_CYCLES - 1);

  typedef enum logic [1:0] {
    BOOT    = 2'd0,
    RUN     = 2'd1,
    MEMWAIT = 2'd2,
    FLUSH   = 2'd3
  } state_t;

  state_t        cur_state, next_state;
  logic [BW-1:0] boot_cnt;
  logic          load_use;
  logic          redirect;
  logic          stall_inc;
  logic          flush_inc;

  assign state    = cur_state;
  assign load_use = ex_mem_read && (ex_rd != 5'd0) &&
                    ((ex_rd == id_rs1) || (ex_rd == id_rs2));

  always_ff @(posedge clk) begin
    if (rst) begin
      cur_state <= BOOT;
      boot_cnt  <= '0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      cur_state <= next_state;
      if (cur_state == BOOT && boot_cnt != BOOT_LAST)
        boot_cnt <= boot_cnt + BW'(1);
      if (stall_inc && stall_cnt != '1)
        stall_cnt <= stall_cnt + CNT_W'(1);
      if (flush_inc && flush_cnt != '1)
        flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

  always_comb begin
    imem_req   = 1'b1;
    pc_we      = 1'b1;
    pc_src     = 1'b0;
    ifid_we    = 1'b1;
    ifid_flush = 1'b0;
    idex_flush = 1'b0;
    next_state = cur_state;
    redirect   = 1'b0;
    stall_inc  = 1'b0;
    flush_inc  = 1'b0;

    case (cur_state)
      BOOT: begin
        imem_req   = 1'b0;
        pc_we      = 1'b0;
        ifid_we    = 1'b0;
        ifid_flush = 1'b1;
        idex_flush = 1'b1;
        if (boot_cnt == BOOT_LAST)
          next_state = RUN;
      end
      RUN: begin
        if (PCSel) begin
          redirect = 1'b1;
        end else if (load_use) begin
          pc_we      = 1'b0;
          ifid_we    = 1'b0;
          idex_flush = 1'b1;
          stall_inc  = 1'b1;
        end else if (!imem_ready) begin
          pc_we      = 1'b0;
          ifid_flush = 1'b1;
          stall_inc  = 1'b1;
          next_state = MEMWAIT;
        end
      end
      MEMWAIT: begin
        if (PCSel) begin
          redirect = 1'b1;
        end else if (!imem_ready) begin
          pc_we      = 1'b0;
          ifid_flush = 1'b1;
          stall_inc  = 1'b1;
        end else begin
          next_state = RUN;
        end
      end
      FLUSH: begin
        ifid_flush = 1'b1;
        if (PCSel) begin
          redirect = 1'b1;
        end else if (!imem_ready) begin
          stall_inc  = 1'b1;
          next_state = MEMWAIT;
        end else begin
          next_state = RUN;
        end
      end
      default: next_state = BOOT;
    endcase

    // Redirect is common to RUN, MEMWAIT and FLUSH; it wins over any stall.
    if (redirect) begin
      pc_src     = 1'b1;
      pc_we      = 1'b1;
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
      flush_inc  = 1'b1;
      stall_inc  = 1'b0;
      next_state = FLUSH;
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: cycle-by-cycle vector table through a scoreboard queue,
// plus a bounded boot-length sequence.
module tb_fetch_ctrl;

  logic       clk;
  logic       rst;
  logic       PCSel;
  logic       ex_mem_read;
  logic [4:0] ex_rd;
  logic [4:0] id_rs1;
  logic [4:0] id_rs2;
  logic       imem_ready;
  logic       imem_req;
  logic       pc_we;
  logic       pc_src;
  logic       ifid_we;
  logic       ifid_flush;
  logic       idex_flush;
  logic [1:0] state;
  logic [3:0] stall_cnt;
  logic [3:0] flush_cnt;

  fetch_ctrl #(.BOOT_CYCLES(4), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .PCSel(PCSel), .ex_mem_read(ex_mem_read),
    .ex_rd(ex_rd), .id_rs1(id_rs1), .id_rs2(id_rs2), .imem_ready(imem_ready),
    .imem_req(imem_req), .pc_we(pc_we), .pc_src(pc_src), .ifid_we(ifid_we),
    .ifid_flush(ifid_flush), .idex_flush(idex_flush), .state(state),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Output bundle order: {imem_req, pc_we, pc_src, ifid_we, ifid_flush, idex_flush}
  localparam logic [5:0] O_BOOT = 6'b000011;
  localparam logic [5:0] O_RUN  = 6'b110100;
  localparam logic [5:0] O_RED  = 6'b111111;
  localparam logic [5:0] O_LU   = 6'b100001;
  localparam logic [5:0] O_WAIT = 6'b100110;
  localparam logic [5:0] O_FL   = 6'b110110;

  typedef struct {
    logic       rst;
    logic       pcsel;
    logic       mr;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       rdy;
    logic [1:0] st;
    logic [5:0] o;
    logic [3:0] sc;
    logic [3:0] fc;
  } vec_t;

  vec_t tbl[$];
  vec_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic add(input logic r, input logic p, input logic m,
                     input logic [4:0] rd, input logic [4:0] r1, input logic [4:0] r2,
                     input logic rdy, input logic [1:0] st, input logic [5:0] o,
                     input int sc, input int fc);
    vec_t v;
    v.rst = r; v.pcsel = p; v.mr = m; v.rd = rd; v.rs1 = r1; v.rs2 = r2;
    v.rdy = rdy; v.st = st; v.o = o; v.sc = 4'(sc); v.fc = 4'(fc);
    tbl.push_back(v);
  endtask

  task automatic idle(input logic [1:0] st, input logic [5:0] o, input int sc, input int fc);
    add(1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1, st, o, sc, fc);
  endtask

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s vec %0d: got %0h want %0h", nm, idx, act, exp);
  endtask

  function automatic int sat(input int v);
    return (v > 15) ? 15 : v;
  endfunction

  initial begin
    int boot_len;
    rst = 1'b1; PCSel = 1'b0; ex_mem_read = 1'b0; ex_rd = '0;
    id_rs1 = '0; id_rs2 = '0; imem_ready = 1'b1;

    // Reset and boot; PCSel / imem_ready must be ignored during BOOT
    add(1, 0, 0, 0, 0, 0, 1, 2'd0, O_BOOT, 0, 0);
    idle(2'd0, O_BOOT, 0, 0);
    add(0, 1, 0, 0, 0, 0, 1, 2'd0, O_BOOT, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 2'd0, O_BOOT, 0, 0);
    idle(2'd0, O_BOOT, 0, 0);
    idle(2'd1, O_RUN, 0, 0);
    // Load-use via rs2, x0 never hazards, load-use via rs1
    add(0, 0, 1, 5, 0, 5, 1, 2'd1, O_LU, 0, 0);
    idle(2'd1, O_RUN, 1, 0);
    add(0, 0, 1, 0, 0, 0, 1, 2'd1, O_RUN, 1, 0);
    add(0, 0, 1, 5, 5, 9, 1, 2'd1, O_LU, 1, 0);
    idle(2'd1, O_RUN, 2, 0);
    // Redirect beats load-use, then one FLUSH cycle
    add(0, 1, 1, 5, 0, 5, 1, 2'd1, O_RED, 2, 0);
    idle(2'd3, O_FL, 2, 1);
    idle(2'd1, O_RUN, 2, 1);
    // Memory wait for 3 cycles
    add(0, 0, 0, 0, 0, 0, 0, 2'd1, O_WAIT, 2, 1);
    add(0, 0, 0, 0, 0, 0, 0, 2'd2, O_WAIT, 3, 1);
    add(0, 0, 0, 0, 0, 0, 0, 2'd2, O_WAIT, 4, 1);
    idle(2'd2, O_RUN, 5, 1);
    idle(2'd1, O_RUN, 5, 1);
    // Redirect from MEMWAIT, redirect again from FLUSH, FLUSH into MEMWAIT
    add(0, 0, 0, 0, 0, 0, 0, 2'd1, O_WAIT, 5, 1);
    add(0, 1, 0, 0, 0, 0, 0, 2'd2, O_RED, 6, 1);
    add(0, 1, 0, 0, 0, 0, 1, 2'd3, O_RED, 6, 2);
    add(0, 0, 0, 0, 0, 0, 0, 2'd3, O_FL, 6, 3);
    idle(2'd2, O_RUN, 7, 3);
    idle(2'd1, O_RUN, 7, 3);
    // Load-use takes priority over imem wait
    add(0, 0, 1, 3, 3, 0, 0, 2'd1, O_LU, 7, 3);
    idle(2'd1, O_RUN, 8, 3);
    // Stall counter saturation
    for (int i = 0; i < 12; i++) add(0, 0, 1, 7, 0, 7, 1, 2'd1, O_LU, sat(8 + i), 3);
    idle(2'd1, O_RUN, 15, 3);
    // Flush counter saturation with back-to-back redirects
    add(0, 1, 0, 0, 0, 0, 1, 2'd1, O_RED, 15, 3);
    for (int k = 1; k < 14; k++) add(0, 1, 0, 0, 0, 0, 1, 2'd3, O_RED, 15, sat(3 + k));
    idle(2'd3, O_FL, 15, 15);
    idle(2'd1, O_RUN, 15, 15);
    // Reset mid-MEMWAIT
    add(0, 0, 0, 0, 0, 0, 0, 2'd1, O_WAIT, 15, 15);
    add(0, 0, 0, 0, 0, 0, 0, 2'd2, O_WAIT, 15, 15);
    add(1, 0, 0, 0, 0, 0, 0, 2'd2, O_WAIT, 15, 15);
    for (int b = 0; b < 4; b++) idle(2'd0, O_BOOT, 0, 0);
    idle(2'd1, O_RUN, 0, 0);
    // Reset mid-FLUSH
    add(0, 1, 0, 0, 0, 0, 1, 2'd1, O_RED, 0, 0);
    add(1, 0, 0, 0, 0, 0, 1, 2'd3, O_FL, 0, 1);
    for (int b = 0; b < 4; b++) idle(2'd0, O_BOOT, 0, 0);
    idle(2'd1, O_RUN, 0, 0);

    @(posedge clk);
    for (int i = 0; i < tbl.size(); i++) begin
      vec_t e;
      @(posedge clk);
      #1;
      rst = tbl[i].rst; PCSel = tbl[i].pcsel; ex_mem_read = tbl[i].mr;
      ex_rd = tbl[i].rd; id_rs1 = tbl[i].rs1; id_rs2 = tbl[i].rs2;
      imem_ready = tbl[i].rdy;
      sb.push_back(tbl[i]);
      #3;
      e = sb.pop_front();
      chk("state", i, 32'(state), 32'(e.st));
      chk("ctrl", i, 32'({imem_req, pc_we, pc_src, ifid_we, ifid_flush, idex_flush}), 32'(e.o));
      chk("stall_cnt", i, 32'(stall_cnt), 32'(e.sc));
      chk("flush_cnt", i, 32'(flush_cnt), 32'(e.fc));
      chk("pc_we_invariant", i, 32'(pc_we && !ifid_we && !ifid_flush), 32'(0));
    end

    // Boot length measured directly, bounded
    @(posedge clk); #1;
    rst = 1'b1; PCSel = 1'b0; ex_mem_read = 1'b0; imem_ready = 1'b1;
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b0;
    #3;
    boot_len = 0;
    for (int c = 0; c < 20; c++) begin
      if (state != 2'd0 || pc_we != 1'b0) break;
      boot_len++;
      @(posedge clk); #4;
    end
    chk("boot_len", 0, 32'(boot_len), 32'(4));
    chk("boot_exit", 0, 32'({state, pc_we}), 32'({2'd1, 1'b1}));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
